noc_endpoint_ni: RTL and testbench
==================================

// Module: noc_endpoint_ni
// PURPOSE
//   Network-interface endpoint sitting on router port 0 (local port). Inject side: packetizes host
//   descriptors into flits and drives the router's port-0 input staging word, gated per VC by
//   can_inject. Eject side: consumes port-0 output staging words, reassembles per-VC wormhole
//   packets and reports one record per tail flit (length, latency, misroute).
// PARAMETERS
//   NUM_VC    4   virtual channels; VC_W = $clog2(NUM_VC)
//   DST_W     14  router/destination id width
//   SEQ_W     8   per-packet flit sequence field width
//   CYC_W     16  cycle/timestamp width
//   LEN_W     8   packet length (flits) width
//   DESC_DEPTH 4  descriptor FIFO depth (power of 2)
//   STG_W = 2+VC_W+DST_W+SEQ_W+CYC_W; word = {full, vc, tail, dst, seq, ts}, MSB first
// PORTS
//   clk          in   1      clock, all state on posedge
//   rst_n        in   1      asynchronous active-low reset
//   my_id        in   DST_W  this endpoint's router id
//   in_cycle     in   CYC_W  current simulated cycle
//   desc_valid   in   1      host descriptor valid
//   desc_ready   out  1      descriptor FIFO not full
//   desc_dst     in   DST_W  packet destination
//   desc_vc      in   VC_W   packet VC
//   desc_len     in   LEN_W  packet length in flits (0 treated as 1)
//   inj_slot     in   1      one-cycle strobe: router samples inj_staging next edge
//   can_inject   in   NUM_VC per-VC router input buffer empty
//   inj_staging  out  STG_W  flit to router port 0; full bit = valid
//   ej_slot      in   1      one-cycle strobe: ej_staging is valid to sample
//   ej_staging   in   STG_W  flit ejected by router port 0
//   rx_valid     out  1      one-cycle pulse: packet completed
//   rx_vc        out  VC_W   VC of completed packet
//   rx_len       out  LEN_W  flits received (saturating)
//   rx_latency   out  CYC_W  in_cycle - head ts, mod 2^CYC_W
//   rx_misroute  out  1      any flit of packet had dst != my_id
//   err_seq      out  1      sticky sequence error
//   done         out  1      FIFO empty, inject FSM IDLE, no partial rx packet
// BEHAVIOUR
//   Reset: all outputs 0 except desc_ready=1, done=1; FIFO, FSM, per-VC rx state cleared.
//   Reset mid-packet: partial tx and rx packets dropped, no rx_valid emitted.
//   FIFO: push on desc_valid&desc_ready; push and pop in same cycle legal when full (pop first).
//   Inject FSM IDLE: FIFO non-empty -> pop, load dst/vc/rem=max(len,1)/seq=0 -> SEND (1 cycle).
//   SEND: on inj_slot & can_inject[cur_vc]: register inj_staging={1,vc,rem==1,dst,seq,ts} for one
//     cycle; ts = in_cycle of head flit, held for all flits; seq++, rem--; tail -> IDLE.
//   SEND, slot without credit: inj_staging full=0, no state change. Max one flit per inj_slot.
//   inj_staging is all-zero in every cycle it is not carrying a flit.
//   Eject: on ej_slot & full bit: per-VC cnt[vc]++ (saturate at 2^LEN_W-1); first flit latches
//     ts; misroute[vc] |= (dst!=my_id). Tail: next cycle rx_valid=1 with vc, cnt, latency,
//     misroute; per-VC state cleared. Flits with full=0 or without ej_slot ignored.
//   Inject and eject are independent; same-cycle inj_slot and ej_slot both serviced.
//   done registered; drops same cycle as descriptor accept, rises cycle after last tail sent.
// CONFIGURATION
//   NI_SEQ_CHECK_EN defined: each ejected flit seq must equal cnt[vc] (mod 2^SEQ_W) before
//     increment; mismatch sets err_seq sticky until reset.
//   Undefined: no check logic, err_seq tied 0.
// TESTING
//   Reset then idle -> done=1, desc_ready=1, inj_staging=0, rx_valid=0.
//   desc{dst=5,vc=1,len=3}, inj_slot every 4 cyc, can_inject=4'hF -> 3 flits seq 0,1,2, tail on 3rd.
//   can_inject[1]=0 for 2 slots mid-packet -> no flit on those slots, then resumes with seq held.
//   Loopback inject->eject, my_id=5, head ts=10, tail at in_cycle=22 -> rx_len=3, rx_latency=12.
//   Interleaved eject on vc0/vc2, one dst=7 -> two rx records, only vc2 rx_misroute=1.
//   NI_SEQ_CHECK_EN, eject seq 0,2 on vc3 -> err_seq=1 and held; without macro err_seq=0.

Source files
------------

// File: rtl/noc_endpoint_ni.sv
// Router port-0 network interface: descriptor FIFO + inject packetizer, per-VC eject reassembly.
// Optional NI_SEQ_CHECK_EN enables the ejected-flit sequence check driving err_seq.
module noc_endpoint_ni #(
  parameter int NUM_VC     = 4,
  parameter int DST_W      = 14,
  parameter int SEQ_W      = 8,
  parameter int CYC_W      = 16,
  parameter int LEN_W      = 8,
  parameter int DESC_DEPTH = 4,
  localparam int VC_W      = $clog2(NUM_VC),
  localparam int STG_W     = 2 + VC_W + DST_W + SEQ_W + CYC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DST_W-1:0]  my_id,
  input  logic [CYC_W-1:0]  in_cycle,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [DST_W-1:0]  desc_dst,
  input  logic [VC_W-1:0]   desc_vc,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              inj_slot,
  input  logic [NUM_VC-1:0] can_inject,
  output logic [STG_W-1:0]  inj_staging,
  input  logic              ej_slot,
  input  logic [STG_W-1:0]  ej_staging,
  output logic              rx_valid,
  output logic [VC_W-1:0]   rx_vc,
  output logic [LEN_W-1:0]  rx_len,
  output logic [CYC_W-1:0]  rx_latency,
  output logic              rx_misroute,
  output logic              err_seq,
  output logic              done
);

  localparam int PTR_W = $clog2(DESC_DEPTH);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [DST_W-1:0] f_dst [DESC_DEPTH];
  logic [VC_W-1:0]  f_vc  [DESC_DEPTH];
  logic [LEN_W-1:0] f_len [DESC_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, fifo_full;

  logic [0:0]       state;
  logic [DST_W-1:0] cur_dst;
  logic [VC_W-1:0]  cur_vc;
  logic [LEN_W-1:0] rem;
  logic [SEQ_W-1:0] seq;
  logic [CYC_W-1:0] head_ts;
  logic             first;
  logic             send;
  logic [CYC_W-1:0] flit_ts;

  // Pop happens only from IDLE, so a full FIFO can still accept while the FSM drains it.
  assign fifo_full  = (count == (PTR_W+1)'(DESC_DEPTH));
  assign pop        = (state == ST_IDLE) && (count != '0);
  assign desc_ready = !fifo_full || pop;
  assign push       = desc_valid && desc_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      f_dst[wr_ptr] <= desc_dst;
      f_vc[wr_ptr]  <= desc_vc;
      f_len[wr_ptr] <= desc_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  assign send    = (state == ST_SEND) && inj_slot && can_inject[cur_vc];
  assign flit_ts = first ? in_cycle : head_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_dst     <= '0;
      cur_vc      <= '0;
      rem         <= '0;
      seq         <= '0;
      head_ts     <= '0;
      first       <= 1'b0;
      inj_staging <= '0;
    end else begin
      inj_staging <= '0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_dst <= f_dst[rd_ptr];
            cur_vc  <= f_vc[rd_ptr];
            rem     <= (f_len[rd_ptr] == '0) ? LEN_W'(1) : f_len[rd_ptr];
            seq     <= '0;
            first   <= 1'b1;
            state   <= ST_SEND;
          end
        end
        default: begin
          if (send) begin
            inj_staging <= {1'b1, cur_vc, (rem == LEN_W'(1)), cur_dst, seq, flit_ts};
            head_ts     <= flit_ts;
            first       <= 1'b0;
            seq         <= seq + SEQ_W'(1);
            rem         <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  logic             ej_full, ej_tail, ej_fire, rx_busy;
  logic [VC_W-1:0]  ej_vc;
  logic [DST_W-1:0] ej_dst;
  logic [SEQ_W-1:0] ej_seq;
  logic [CYC_W-1:0] ej_ts, ej_head_ts;
  logic [LEN_W-1:0] cnt_cur, cnt_inc;
  logic             mis_new;
  logic [LEN_W-1:0] cnt    [NUM_VC];
  logic [CYC_W-1:0] rx_ts  [NUM_VC];
  logic             mis    [NUM_VC];

  assign ej_full    = ej_staging[STG_W-1];
  assign ej_vc      = ej_staging[STG_W-2 -: VC_W];
  assign ej_tail    = ej_staging[STG_W-2-VC_W];
  assign ej_dst     = ej_staging[SEQ_W+CYC_W +: DST_W];
  assign ej_seq     = ej_staging[CYC_W +: SEQ_W];
  assign ej_ts      = ej_staging[CYC_W-1:0];
  assign ej_fire    = ej_slot && ej_full;
  assign cnt_cur    = cnt[ej_vc];
  assign cnt_inc    = (cnt_cur == '1) ? cnt_cur : cnt_cur + LEN_W'(1);
  assign ej_head_ts = (cnt_cur == '0) ? ej_ts : rx_ts[ej_vc];
  assign mis_new    = mis[ej_vc] || (ej_dst != my_id);

  always_comb begin
    rx_busy = 1'b0;
    for (int i = 0; i < NUM_VC; i++) if (cnt[i] != '0) rx_busy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid    <= 1'b0;
      rx_vc       <= '0;
      rx_len      <= '0;
      rx_latency  <= '0;
      rx_misroute <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
        cnt[i]   <= '0;
        rx_ts[i] <= '0;
        mis[i]   <= 1'b0;
      end
    end else begin
      rx_valid <= 1'b0;
      if (ej_fire) begin
        if (ej_tail) begin
          rx_valid     <= 1'b1;
          rx_vc        <= ej_vc;
          rx_len       <= cnt_inc;
          rx_latency   <= in_cycle - ej_head_ts;
          rx_misroute  <= mis_new;
          cnt[ej_vc]   <= '0;
          mis[ej_vc]   <= 1'b0;
        end else begin
          cnt[ej_vc]   <= cnt_inc;
          rx_ts[ej_vc] <= ej_head_ts;
          mis[ej_vc]   <= mis_new;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b1;
    else        done <= (count == '0) && !push && (state == ST_IDLE) && !rx_busy;
  end

`ifdef NI_SEQ_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_seq <= 1'b0;
    else if (ej_fire && (ej_seq != SEQ_W'(cnt_cur))) err_seq <= 1'b1;
  end
`else
  assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_noc_endpoint_ni.sv
// Bench for noc_endpoint_ni: inject/eject scoreboards, eject vector table, corner sequences.
module tb_noc_endpoint_ni;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] my_id;
  logic [15:0] in_cycle;
  logic        desc_valid, desc_ready;
  logic [13:0] desc_dst;
  logic [1:0]  desc_vc;
  logic [7:0]  desc_len;
  logic        inj_slot;
  logic [3:0]  can_inject;
  logic [41:0] inj_staging;
  logic        ej_slot;
  logic [41:0] ej_staging;
  logic        rx_valid;
  logic [1:0]  rx_vc;
  logic [7:0]  rx_len;
  logic [15:0] rx_latency;
  logic        rx_misroute, err_seq, done;

  noc_endpoint_ni dut (
    .clk(clk), .rst_n(rst_n), .my_id(my_id), .in_cycle(in_cycle),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dst(desc_dst),
    .desc_vc(desc_vc), .desc_len(desc_len), .inj_slot(inj_slot),
    .can_inject(can_inject), .inj_staging(inj_staging), .ej_slot(ej_slot),
    .ej_staging(ej_staging), .rx_valid(rx_valid), .rx_vc(rx_vc), .rx_len(rx_len),
    .rx_latency(rx_latency), .rx_misroute(rx_misroute), .err_seq(err_seq), .done(done)
  );

  always #5 clk = ~clk;

`ifdef NI_SEQ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic        slot;
    logic        full;
    logic [1:0]  vc;
    logic        tail;
    logic [13:0] dst;
    logic [7:0]  seq;
    logic [15:0] ts;
    logic [15:0] cyc;
    logic [7:0]  exp_len;
    logic [15:0] exp_lat;
    logic        exp_mis;
  } ej_vec_t;

  typedef struct packed {
    logic [1:0]  vc;
    logic [7:0]  len;
    logic [15:0] lat;
    logic        mis;
  } rx_exp_t;

  int          vecs = 0;
  int          errs = 0;
  logic [41:0] inj_q [$];
  rx_exp_t     rx_q  [$];
  logic [15:0] head_ts;
  logic [41:0] w;
  ej_vec_t     tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    in_cycle = in_cycle + 16'd1;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inj_staging[41]) begin
        if (inj_q.size() == 0) chk("inj_unexpected", {22'd0, inj_staging}, 64'd0);
        else                   chk("inj_flit", {22'd0, inj_staging}, {22'd0, inj_q.pop_front()});
      end else if (inj_staging != '0) begin
        chk("inj_idle_zero", {22'd0, inj_staging}, 64'd0);
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) chk("rx_unexpected", {37'd0, rx_vc, rx_len, rx_latency, rx_misroute}, 64'd0);
        else chk("rx_record", {37'd0, rx_vc, rx_len, rx_latency, rx_misroute}, {37'd0, rx_q.pop_front()});
      end
    end
  end

  task automatic push_desc(input logic [13:0] dst, input logic [1:0] vc, input logic [7:0] len);
    desc_dst = dst; desc_vc = vc; desc_len = len; desc_valid = 1'b1;
    for (int i = 0; i < 20 && !desc_ready; i++) tick;
    if (!desc_ready) chk("desc_ready_timeout", 64'd0, 64'd1);
    tick;
    desc_valid = 1'b0;
  endtask

  task automatic slot(input logic exp, input logic [1:0] vc, input logic tail,
                      input logic [13:0] dst, input logic [7:0] seq);
    inj_slot = 1'b1;
    if (exp) begin
      if (seq == 8'd0) head_ts = in_cycle;
      inj_q.push_back({1'b1, vc, tail, dst, seq, head_ts});
    end
    tick;
    inj_slot = 1'b0;
    if (!exp) chk("no_flit_on_slot", {22'd0, inj_staging}, 64'd0);
    repeat (3) tick;
  endtask

  task automatic eject(input ej_vec_t v);
    ej_slot    = v.slot;
    ej_staging = {v.full, v.vc, v.tail, v.dst, v.seq, v.ts};
    in_cycle   = v.cyc;
    if (v.slot && v.full && v.tail) rx_q.push_back({v.vc, v.exp_len, v.exp_lat, v.exp_mis});
    tick;
    ej_slot = 1'b0; ej_staging = '0;
    tick;
  endtask

  initial begin
    //        slot full vc   tail dst     seq    ts       cyc      len   lat        mis
    tbl[0] = '{1'b1, 1'b1, 2'd0, 1'b0, 14'd5, 8'd0, 16'd100, 16'd105, 8'd0, 16'd0,     1'b0};
    tbl[1] = '{1'b1, 1'b1, 2'd2, 1'b0, 14'd5, 8'd0, 16'd200, 16'd106, 8'd0, 16'd0,     1'b0};
    tbl[2] = '{1'b1, 1'b1, 2'd0, 1'b0, 14'd5, 8'd1, 16'd100, 16'd107, 8'd0, 16'd0,     1'b0};
    tbl[3] = '{1'b1, 1'b1, 2'd2, 1'b0, 14'd7, 8'd1, 16'd200, 16'd108, 8'd0, 16'd0,     1'b0};
    tbl[4] = '{1'b1, 1'b1, 2'd0, 1'b1, 14'd5, 8'd2, 16'd100, 16'd110, 8'd3, 16'd10,    1'b0};
    tbl[5] = '{1'b1, 1'b1, 2'd2, 1'b1, 14'd5, 8'd2, 16'd200, 16'd112, 8'd3, 16'd65448, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 2'd1, 1'b1, 14'd5, 8'd0, 16'd50,  16'd60,  8'd1, 16'd10,    1'b0};
    tbl[7] = '{1'b1, 1'b0, 2'd1, 1'b1, 14'd9, 8'd5, 16'd70,  16'd80,  8'd0, 16'd0,     1'b0};
    tbl[8] = '{1'b0, 1'b1, 2'd3, 1'b1, 14'd9, 8'd5, 16'd70,  16'd81,  8'd0, 16'd0,     1'b0};

    rst_n = 1'b0; my_id = 14'd5; in_cycle = '0; desc_valid = 1'b0; desc_dst = '0;
    desc_vc = '0; desc_len = '0; inj_slot = 1'b0; can_inject = 4'hF;
    ej_slot = 1'b0; ej_staging = '0; head_ts = '0;
    repeat (3) tick;
    chk("rst_done", {63'd0, done}, 64'd1);
    chk("rst_desc_ready", {63'd0, desc_ready}, 64'd1);
    chk("rst_inj_staging", {22'd0, inj_staging}, 64'd0);
    rst_n = 1'b1;
    tick;
    chk("idle_done", {63'd0, done}, 64'd1);
    chk("idle_desc_ready", {63'd0, desc_ready}, 64'd1);
    chk("idle_rx_valid", {63'd0, rx_valid}, 64'd0);
    chk("idle_err_seq", {63'd0, err_seq}, 64'd0);

    // Basic 3-flit packet.
    push_desc(14'd5, 2'd1, 8'd3);
    repeat (2) tick;
    chk("busy_done", {63'd0, done}, 64'd0);
    slot(1'b1, 2'd1, 1'b0, 14'd5, 8'd0);
    slot(1'b1, 2'd1, 1'b0, 14'd5, 8'd1);
    slot(1'b1, 2'd1, 1'b1, 14'd5, 8'd2);
    slot(1'b0, 2'd1, 1'b0, 14'd5, 8'd0);
    chk("drained_done", {63'd0, done}, 64'd1);

    // Credit withheld mid-packet.
    push_desc(14'd5, 2'd1, 8'd3);
    repeat (2) tick;
    slot(1'b1, 2'd1, 1'b0, 14'd5, 8'd0);
    can_inject = 4'b1101;
    slot(1'b0, 2'd1, 1'b0, 14'd5, 8'd0);
    slot(1'b0, 2'd1, 1'b0, 14'd5, 8'd0);
    can_inject = 4'hF;
    slot(1'b1, 2'd1, 1'b0, 14'd5, 8'd1);
    slot(1'b1, 2'd1, 1'b1, 14'd5, 8'd2);

    // FIFO fill with no credit, len 0 treated as 1.
    can_inject = 4'h0;
    for (int i = 0; i < 5; i++) push_desc(14'd100 + 14'(i), 2'd0, (i == 0) ? 8'd0 : 8'd1);
    chk("fifo_full_ready", {63'd0, desc_ready}, 64'd0);
    desc_dst = 14'd999; desc_valid = 1'b1;
    repeat (2) tick;
    desc_valid = 1'b0;
    can_inject = 4'b0001;
    for (int i = 0; i < 5; i++) slot(1'b1, 2'd0, 1'b1, 14'd100 + 14'(i), 8'd0);
    slot(1'b0, 2'd0, 1'b0, 14'd0, 8'd0);
    chk("fifo_drained_done", {63'd0, done}, 64'd1);
    can_inject = 4'hF;

    // Loopback: head ts 10, tail ejected at cycle 22.
    push_desc(14'd5, 2'd1, 8'd3);
    repeat (2) tick;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) in_cycle = 16'd10;
      inj_slot = 1'b1;
      inj_q.push_back({1'b1, 2'd1, (k == 2), 14'd5, 8'(k), 16'd10});
      tick;
      inj_slot = 1'b0;
      w = inj_staging;
      ej_slot = 1'b1; ej_staging = w;
      in_cycle = (k == 2) ? 16'd22 : 16'd12 + 16'(2 * k);
      if (k == 2) rx_q.push_back({2'd1, 8'd3, 16'd12, 1'b0});
      tick;
      ej_slot = 1'b0; ej_staging = '0;
      tick;
    end
    repeat (2) tick;

    // Interleaved eject table, misroute and ignored flits.
    for (int i = 0; i < 9; i++) eject(tbl[i]);
    repeat (2) tick;
    chk("err_seq_clean", {63'd0, err_seq}, 64'd0);

    // Sequence gap on vc3.
    eject('{1'b1, 1'b1, 2'd3, 1'b0, 14'd5, 8'd0, 16'd300, 16'd301, 8'd0, 16'd0, 1'b0});
    eject('{1'b1, 1'b1, 2'd3, 1'b1, 14'd5, 8'd2, 16'd300, 16'd305, 8'd2, 16'd5, 1'b0});
    repeat (3) tick;
    chk("err_seq_set", {63'd0, err_seq}, {63'd0, EXP_ERR});
    repeat (5) tick;
    chk("err_seq_held", {63'd0, err_seq}, {63'd0, EXP_ERR});

    // Reset in the middle of tx and rx packets.
    eject('{1'b1, 1'b1, 2'd0, 1'b0, 14'd5, 8'd0, 16'd400, 16'd401, 8'd0, 16'd0, 1'b0});
    push_desc(14'd5, 2'd2, 8'd3);
    repeat (2) tick;
    slot(1'b1, 2'd2, 1'b0, 14'd5, 8'd0);
    rst_n = 1'b0;
    tick;
    chk("mrst_done", {63'd0, done}, 64'd1);
    chk("mrst_rx_valid", {63'd0, rx_valid}, 64'd0);
    chk("mrst_err_seq", {63'd0, err_seq}, 64'd0);
    rst_n = 1'b1;
    tick;
    slot(1'b0, 2'd2, 1'b0, 14'd5, 8'd0);
    eject('{1'b1, 1'b1, 2'd0, 1'b1, 14'd5, 8'd0, 16'd500, 16'd503, 8'd1, 16'd3, 1'b0});
    repeat (3) tick;
    chk("post_rst_err_seq", {63'd0, err_seq}, 64'd0);
    chk("final_done", {63'd0, done}, 64'd1);
    chk("inj_q_empty", 64'(inj_q.size()), 64'd0);
    chk("rx_q_empty", 64'(rx_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
